// File: rtl/uart_rx_deserializer.sv
// UART receive path: 2-flop synchroniser, mid-bit sampling FSM, parity/stop checks,
// sticky error flags and a first-word-fall-through FIFO of accepted words.
module uart_rx_deserializer #(
  parameter int SYSCLK_RATE = 9600000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_WIDTH  = 4,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 SysClk,
  input  logic                 Reset_n,
  input  logic                 RxD,
  input  logic                 RxRead,
  input  logic                 ErrClear,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxFull,
  output logic                 Busy,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overrun
);

  localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam int CNTW = $clog2(FIFO_WIDTH + 1);
  localparam logic PAR_REF = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t r_state, w_state_nxt;

  logic                 r_sync1, r_sync2, r_rx_prev;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad, r_frm_bad;
  logic [DATA_BITS-1:0] r_mem [FIFO_WIDTH];
  logic [PW-1:0]        r_wr, r_rd;
  logic [CNTW-1:0]      r_count;
  logic                 r_par_err, r_frm_err, r_ovr;

  logic w_rx, w_tick;
  logic w_ld_half, w_ld_full, w_clr_bits;
  logic w_samp_data, w_samp_par, w_samp_stop, w_commit;
  logic w_frm_now, w_good, w_full, w_push, w_pop, w_ovr_set;

  assign w_rx   = r_sync2;
  assign w_tick = (r_cnt == '0);

  // Line synchroniser plus one-cycle history for falling-edge detection.
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= RxD;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_half   = 1'b0;
    w_ld_full   = 1'b0;
    w_clr_bits  = 1'b0;
    w_samp_data = 1'b0;
    w_samp_par  = 1'b0;
    w_samp_stop = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_prev && !w_rx) begin
          w_state_nxt = START;
          w_ld_half   = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          if (!w_rx) begin
            w_state_nxt = DATA;
            w_ld_full   = 1'b1;
            w_clr_bits  = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          w_samp_data = 1'b1;
          w_ld_full   = 1'b1;
          if (r_bitcnt == 3'(DATA_BITS - 1)) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_samp_par  = 1'b1;
          w_ld_full   = 1'b1;
          w_clr_bits  = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_samp_stop = 1'b1;
          if (r_bitcnt == 3'(STOP_BITS - 1)) begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ld_full = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_frm_bad <= 1'b0;
    end else begin
      if (w_ld_half)      r_cnt <= CW'(CLKS_PER_BIT / 2 - 1);
      else if (w_ld_full) r_cnt <= CW'(CLKS_PER_BIT - 1);
      else if (!w_tick)   r_cnt <= r_cnt - CW'(1);

      if (w_clr_bits)                     r_bitcnt <= '0;
      else if (w_samp_data || w_samp_stop) r_bitcnt <= r_bitcnt + 3'd1;

      // LSB arrives first, so shift right and insert at the MSB.
      if (w_samp_data) r_shift <= (r_shift >> 1) | (DATA_BITS'(w_rx) << (DATA_BITS - 1));

      if (w_samp_par) r_par_bad <= (((^r_shift) ^ w_rx) != PAR_REF);

      if (w_clr_bits)                r_frm_bad <= 1'b0;
      else if (w_samp_stop && !w_rx) r_frm_bad <= 1'b1;
    end
  end

  // The last stop sample is folded in combinationally so commit happens on that cycle.
  assign w_frm_now = r_frm_bad | (w_samp_stop & ~w_rx);
  assign w_good    = w_commit & ~r_par_bad & ~w_frm_now;
  assign w_full    = (r_count == CNTW'(FIFO_WIDTH));
  assign w_pop     = RxRead & (r_count != '0);
  assign w_push    = w_good & (~w_full | w_pop);
  assign w_ovr_set = w_good & w_full & ~RxRead;

  always_ff @(posedge SysClk) begin
    if (w_push) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(FIFO_WIDTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == PW'(FIFO_WIDTH - 1)) ? '0 : r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A set event in the same cycle as ErrClear takes priority.
  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_par_err <= (w_commit & r_par_bad) | (r_par_err & ~ErrClear);
      r_frm_err <= (w_commit & w_frm_now) | (r_frm_err & ~ErrClear);
      r_ovr     <= w_ovr_set | (r_ovr & ~ErrClear);
    end
  end

  assign RxValid   = (r_count != '0);
  assign RxFull    = w_full;
  assign RxData    = RxValid ? r_mem[r_rd] : '0;
  assign Busy      = (r_state != IDLE);
  assign ParityErr = r_par_err;
  assign FrameErr  = r_frm_err;
  assign Overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at 100 clocks per bit, 8E2, 4-entry FIFO.
module tb_uart_rx_deserializer;

  localparam int CPB  = 100;
  localparam int FIFO = 4;

  logic       SysClk = 1'b0;
  logic       Reset_n, RxD, RxRead, ErrClear;
  logic [7:0] RxData;
  logic       RxValid, RxFull, Busy, ParityErr, FrameErr, Overrun;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  always #5 SysClk = ~SysClk;

  uart_rx_deserializer #(
    .SYSCLK_RATE(CPB * 9600), .BAUD_RATE(9600), .DATA_BITS(8),
    .STOP_BITS(2), .FIFO_WIDTH(FIFO), .PARITY_ODD(0)
  ) dut (
    .SysClk(SysClk), .Reset_n(Reset_n), .RxD(RxD), .RxRead(RxRead),
    .ErrClear(ErrClear), .RxData(RxData), .RxValid(RxValid), .RxFull(RxFull),
    .Busy(Busy), .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge SysClk);
  endtask

  // Serial frame: start, 8 data LSB-first, parity, stop1, stop2 (always 1).
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop1);
    logic p;
    p = (^d) ^ bad_par;
    RxD = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin RxD = d[i]; cyc(CPB); end
    RxD = p;     cyc(CPB);
    RxD = stop1; cyc(CPB);
    RxD = 1'b1;  cyc(CPB);
    if (!bad_par && stop1) begin
      if (exp_q.size() < FIFO) exp_q.push_back(d);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic read_one(input string nm);
    logic [7:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s: scoreboard empty, RxValid=%b", nm, RxValid);
    end else begin
      e = exp_q.pop_front();
      if (RxValid !== 1'b1 || RxData !== e) begin
        n_fail++; $display("FAIL %s: RxValid=%b RxData=%h, required 1 / %h", nm, RxValid, RxData, e);
      end
    end
    RxRead = 1'b1; cyc(1); RxRead = 1'b0; cyc(1);
  endtask

  task automatic chk_flags(input string nm, input logic pe, input logic fe, input logic ov, input logic vld);
    n_chk++;
    if ({ParityErr, FrameErr, Overrun, RxValid} !== {pe, fe, ov, vld}) begin
      n_fail++;
      $display("FAIL %s: PE/FE/OV/Valid=%b%b%b%b, required %b%b%b%b", nm,
               ParityErr, FrameErr, Overrun, RxValid, pe, fe, ov, vld);
    end
  endtask

  task automatic clear_errs();
    ErrClear = 1'b1; cyc(1); ErrClear = 1'b0; cyc(1);
    exp_ovr = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; RxD = 1'b1; RxRead = 1'b0; ErrClear = 1'b0;
    cyc(3);
    chk_flags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({RxFull, Busy} !== 2'b00 || RxData !== 8'h00) begin
      n_fail++; $display("FAIL reset_out: RxFull=%b Busy=%b RxData=%h, required 0 0 00", RxFull, Busy, RxData);
    end
    Reset_n = 1'b1; cyc(5);
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0, 1'b1);
    chk_flags("a5_flags", 1'b0, 1'b0, 1'b0, 1'b1);
    read_one("a5_data");
    chk_flags("a5_popped", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1);
    chk_flags("par_err", 1'b1, 1'b0, 1'b0, 1'b0);
    clear_errs();
    chk_flags("par_clr", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_flags("frm_err", 1'b0, 1'b1, 1'b0, 1'b0);
    clear_errs();
    send_frame(8'h3C, 1'b0, 1'b1);
    chk_flags("frm_recover", 1'b0, 1'b0, 1'b0, 1'b1);
    read_one("frm_3c");
  endtask

  task automatic test_false_start();
    RxD = 1'b0; cyc(20);
    n_chk++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: Busy=%b, required 1", Busy); end
    cyc(10); RxD = 1'b1; cyc(CPB);
    n_chk++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: Busy=%b, required 0", Busy); end
    chk_flags("glitch_flags", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_break();
    RxD = 1'b0; cyc(13 * CPB);
    chk_flags("break_frm", 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL break_idle: Busy=%b, required 0", Busy); end
    RxD = 1'b1; cyc(CPB);
    clear_errs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      send_frame(words[i], 1'b0, 1'b1);
      if (i == 3) begin
        n_chk++;
        if (RxFull !== 1'b1) begin n_fail++; $display("FAIL b2b_full: RxFull=%b, required 1", RxFull); end
      end
    end
    chk_flags("b2b_overrun", 1'b0, 1'b0, exp_ovr, 1'b1);
    for (int i = 0; i < 4; i++) read_one("b2b_data");
    chk_flags("b2b_drained", 1'b0, 1'b0, exp_ovr, 1'b0);
  endtask

  task automatic test_reset_midframe();
    RxD = 1'b0; cyc(CPB);
    for (int i = 0; i < 4; i++) begin RxD = 1'b1; cyc(i == 3 ? CPB / 2 : CPB); end
    Reset_n = 1'b0; cyc(2);
    exp_q.delete(); exp_ovr = 1'b0;
    chk_flags("mid_rst_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({RxFull, Busy} !== 2'b00 || RxData !== 8'h00) begin
      n_fail++; $display("FAIL mid_rst_out: RxFull=%b Busy=%b RxData=%h, required 0 0 00", RxFull, Busy, RxData);
    end
    RxD = 1'b1; cyc(2); Reset_n = 1'b1; cyc(CPB);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk_flags("after_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    read_one("after_rst_5a");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_false_start();
    test_break();
    test_back_to_back();
    clear_errs();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
